// File: rtl/pc_unit.sv
// pc_unit: fetch-stage PC register with stall, branch/jump redirect and sticky halt; optional PC_STEP_MODE_EN gates advances on i_step
module pc_unit #(
  parameter int                   BUS_WIDTH = 32,
  parameter int                   INC_STEP  = 1,
  parameter logic [BUS_WIDTH-1:0] RESET_PC  = '0
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 i_enable,
  input  logic                 i_stall,
  input  logic                 i_branch_taken,
  input  logic [BUS_WIDTH-1:0] i_branch_target,
  input  logic                 i_jump,
  input  logic [BUS_WIDTH-1:0] i_jump_target,
  input  logic                 i_halt,
`ifdef PC_STEP_MODE_EN
  input  logic                 i_step,
`endif
  output logic [BUS_WIDTH-1:0] o_pc,
  output logic [BUS_WIDTH-1:0] o_pc_plus,
  output logic                 o_valid,
  output logic                 o_halted
);
  typedef enum logic [1:0] {RUN = 2'd0, STALL = 2'd1, HALT = 2'd2} state_t;
  state_t               r_state, w_state_nxt;
  logic [BUS_WIDTH-1:0] r_pc, w_pc_nxt;
  logic                 r_valid, w_valid_nxt;
  logic                 w_step, w_redir;
`ifdef PC_STEP_MODE_EN
  assign w_step = i_step;
`else
  assign w_step = 1'b1;
`endif
  assign w_redir   = (i_branch_taken | i_jump) & w_step;
  assign o_pc      = r_pc;
  assign o_pc_plus = r_pc + BUS_WIDTH'(INC_STEP);
  assign o_valid   = r_valid;
  assign o_halted  = (r_state == HALT);
  // next state and next PC; a redirect squashes a same-cycle halt, and the halt cycle itself holds the PC
  always_comb begin
    w_state_nxt = r_state;
    w_pc_nxt    = r_pc;
    w_valid_nxt = 1'b0;
    if (r_state != HALT) begin
      if (w_redir) begin
        w_pc_nxt    = i_branch_taken ? i_branch_target : i_jump_target;
        w_valid_nxt = 1'b1;
        w_state_nxt = RUN;
      end else if (i_halt) begin
        w_state_nxt = HALT;
      end else begin
        w_state_nxt = i_stall ? STALL : RUN;
        w_valid_nxt = !i_stall && i_enable && w_step;
        w_pc_nxt    = w_valid_nxt ? o_pc_plus : r_pc;
      end
    end
  end
  // state, PC and valid registers with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= RUN;
      r_pc    <= RESET_PC;
      r_valid <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_pc    <= w_pc_nxt;
      r_valid <= w_valid_nxt;
    end
  end
endmodule

// File: tb/tb_pc_unit.sv
// tb_pc_unit: directed tests for pc_unit (32-bit step 1 and 8-bit step 4 instances)
module tb_pc_unit;
  logic        clk = 1'b0, reset = 1'b1;
  logic        en = 1'b0, stall = 1'b0, br = 1'b0, jmp = 1'b0, halt = 1'b0, step = 1'b1;
  logic [31:0] bt = '0, jt = '0;
  logic [31:0] pc, pcp;
  logic        valid, halted;
  logic [7:0]  pc8, pcp8;
  logic        valid8, halted8;
  int          n_chk = 0, n_fail = 0;

  always #5 clk = ~clk;

  pc_unit dut (
    .clk(clk), .reset(reset), .i_enable(en), .i_stall(stall),
    .i_branch_taken(br), .i_branch_target(bt), .i_jump(jmp), .i_jump_target(jt),
    .i_halt(halt),
`ifdef PC_STEP_MODE_EN
    .i_step(step),
`endif
    .o_pc(pc), .o_pc_plus(pcp), .o_valid(valid), .o_halted(halted));

  pc_unit #(.BUS_WIDTH(8), .INC_STEP(4), .RESET_PC(8'h00)) dut8 (
    .clk(clk), .reset(reset), .i_enable(en), .i_stall(stall),
    .i_branch_taken(br), .i_branch_target(bt[7:0]), .i_jump(jmp), .i_jump_target(jt[7:0]),
    .i_halt(halt),
`ifdef PC_STEP_MODE_EN
    .i_step(step),
`endif
    .o_pc(pc8), .o_pc_plus(pcp8), .o_valid(valid8), .o_halted(halted8));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick();
    tick();
    n_chk++; if (pc !== 32'd0) begin n_fail++; $display("FAIL reset_pc got %0h want 0", pc); end
    n_chk++; if (pcp !== 32'd1) begin n_fail++; $display("FAIL reset_pc_plus got %0h want 1", pcp); end
    n_chk++; if (valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %b want 0", valid); end
    n_chk++; if (halted !== 1'b0) begin n_fail++; $display("FAIL reset_halted got %b want 0", halted); end
    reset = 1'b0;
  endtask

  task automatic test_increment();
    en = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      tick();
      n_chk++; if (pc !== 32'(k)) begin n_fail++; $display("FAIL inc_pc got %0h want %0h", pc, k); end
      n_chk++; if (pcp !== 32'(k + 1)) begin n_fail++; $display("FAIL inc_pc_plus got %0h want %0h", pcp, k + 1); end
      n_chk++; if (valid !== 1'b1) begin n_fail++; $display("FAIL inc_valid got %b want 1", valid); end
    end
  endtask

  task automatic test_stall();
    stall = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      n_chk++; if (pc !== 32'd5 || valid !== 1'b0) begin n_fail++; $display("FAIL stall_hold got pc=%0h v=%b want pc=5 v=0", pc, valid); end
    end
    stall = 1'b0;
    tick();
    n_chk++; if (pc !== 32'd6 || valid !== 1'b1) begin n_fail++; $display("FAIL stall_release got pc=%0h v=%b want pc=6 v=1", pc, valid); end
    en = 1'b0;
    tick();
    n_chk++; if (pc !== 32'd6 || valid !== 1'b0) begin n_fail++; $display("FAIL disabled_hold got pc=%0h v=%b want pc=6 v=0", pc, valid); end
    en = 1'b1;
  endtask

  task automatic test_branch_over_stall();
    stall = 1'b1; br = 1'b1; bt = 32'h40;
    tick();
    n_chk++; if (pc !== 32'h40 || valid !== 1'b1) begin n_fail++; $display("FAIL branch_flush got pc=%0h v=%b want pc=40 v=1", pc, valid); end
    stall = 1'b0; br = 1'b0;
    tick();
    n_chk++; if (pc !== 32'h41) begin n_fail++; $display("FAIL post_branch_run got %0h want 41", pc); end
  endtask

  task automatic test_priority();
    br = 1'b1; bt = 32'h80; jmp = 1'b1; jt = 32'h20;
    tick();
    n_chk++; if (pc !== 32'h80) begin n_fail++; $display("FAIL branch_over_jump got %0h want 80", pc); end
    br = 1'b0;
    tick();
    n_chk++; if (pc !== 32'h20) begin n_fail++; $display("FAIL jump_only got %0h want 20", pc); end
    halt = 1'b1; jt = 32'h08;
    tick();
    n_chk++; if (pc !== 32'h08 || halted !== 1'b0) begin n_fail++; $display("FAIL halt_with_jump got pc=%0h h=%b want pc=8 h=0", pc, halted); end
    halt = 1'b0; jmp = 1'b0;
    tick();
    n_chk++; if (pc !== 32'h09) begin n_fail++; $display("FAIL after_shadow got %0h want 9", pc); end
  endtask

  task automatic test_halt();
    halt = 1'b1;
    tick();
    n_chk++; if (pc !== 32'h09 || halted !== 1'b1 || valid !== 1'b0) begin n_fail++; $display("FAIL halt_enter got pc=%0h h=%b v=%b want pc=9 h=1 v=0", pc, halted, valid); end
    halt = 1'b0;
    for (int k = 0; k < 4; k++) begin
      br = k[0]; jmp = k[1]; en = ~k[0]; bt = 32'h55; jt = 32'h66;
      tick();
      n_chk++; if (pc !== 32'h09 || halted !== 1'b1 || valid !== 1'b0) begin n_fail++; $display("FAIL halt_sticky got pc=%0h h=%b v=%b want pc=9 h=1 v=0", pc, halted, valid); end
    end
    br = 1'b0; jmp = 1'b0; en = 1'b1;
    reset = 1'b1;
    tick();
    n_chk++; if (pc !== 32'd0 || halted !== 1'b0 || valid !== 1'b0) begin n_fail++; $display("FAIL halt_reset got pc=%0h h=%b v=%b want pc=0 h=0 v=0", pc, halted, valid); end
    reset = 1'b0;
  endtask

  task automatic test_wrap();
    br = 1'b1; bt = 32'hFFFF_FFFC;
    tick();
    br = 1'b0;
    n_chk++; if (pc8 !== 8'hFC) begin n_fail++; $display("FAIL wrap8_load got %0h want fc", pc8); end
    n_chk++; if (pcp8 !== 8'h00) begin n_fail++; $display("FAIL wrap8_plus got %0h want 0", pcp8); end
    tick();
    n_chk++; if (pc8 !== 8'h00 || valid8 !== 1'b1 || halted8 !== 1'b0) begin n_fail++; $display("FAIL wrap8_inc got pc=%0h v=%b want pc=0 v=1", pc8, valid8); end
    n_chk++; if (pc !== 32'hFFFF_FFFD) begin n_fail++; $display("FAIL wide_inc got %0h want fffffffd", pc); end
    jmp = 1'b1; jt = 32'hFFFF_FFFF;
    tick();
    jmp = 1'b0;
    n_chk++; if (pcp !== 32'd0) begin n_fail++; $display("FAIL wrap32_plus got %0h want 0", pcp); end
    tick();
    n_chk++; if (pc !== 32'd0 || valid !== 1'b1) begin n_fail++; $display("FAIL wrap32_inc got pc=%0h v=%b want pc=0 v=1", pc, valid); end
  endtask

`ifdef PC_STEP_MODE_EN
  task automatic test_step_mode();
    step = 1'b0;
    tick();
    n_chk++; if (pc !== 32'd0 || valid !== 1'b0) begin n_fail++; $display("FAIL step_hold got pc=%0h v=%b want pc=0 v=0", pc, valid); end
    step = 1'b1;
    tick();
    n_chk++; if (pc !== 32'd1 || valid !== 1'b1) begin n_fail++; $display("FAIL step_adv got pc=%0h v=%b want pc=1 v=1", pc, valid); end
    step = 1'b0; br = 1'b1; bt = 32'h70;
    tick();
    n_chk++; if (pc !== 32'd1) begin n_fail++; $display("FAIL step_branch_hold got %0h want 1", pc); end
    step = 1'b1;
    tick();
    br = 1'b0;
    n_chk++; if (pc !== 32'h70) begin n_fail++; $display("FAIL step_branch got %0h want 70", pc); end
  endtask
`endif

  initial begin
    test_reset();
    test_increment();
    test_stall();
    test_branch_over_stall();
    test_priority();
    test_halt();
    test_wrap();
`ifdef PC_STEP_MODE_EN
    test_step_mode();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
